// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment scan driver and its decoder.
package seven_seg_pkg;

   // Width of one BCD digit, matching the decoder's binary_input.
   localparam int DIGIT_W          = 4;

   // Default geometry and timing of the scan.
   localparam int DEF_NUM_DIGITS   = 4;
   localparam int DEF_CLK_DIV      = 50000;
   localparam int DEF_GUARD_CYCLES = 2;

   // What the current slot is doing.
   typedef enum logic [1:0] {
      PH_GUARD = 2'd0,   // anti-ghosting gap at the start of every slot
      PH_DRIVE = 2'd1,   // digit enable asserted
      PH_BLANK = 2'd2    // leading zero suppressed for the whole slot
   } slot_phase_e;

endpackage

// File: rtl/seven_seg_scan_driver_scan_tick_gen.sv
// Prescaler and slot index for the scan: cnt runs 0..CLK_DIV-1 inside each
// slot, idx steps through the digits and wraps once per frame.
module scan_tick_gen
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS = DEF_NUM_DIGITS,
   parameter int CLK_DIV    = DEF_CLK_DIV,
   parameter int CNT_W      = $clog2(CLK_DIV),
   parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [CNT_W-1:0] cnt,
   output logic [IDX_W-1:0] idx,
   output logic             tick,
   output logic             frame_wrap
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [IDX_W-1:0] idx_reg, idx_next;

   assign tick       = (cnt_reg == CNT_LAST);
   assign frame_wrap = tick && (idx_reg == IDX_LAST);
   assign cnt        = cnt_reg;
   assign idx        = idx_reg;

   // Next prescaler/slot values: count within the slot, advance the slot on tick.
   always_comb begin
      cnt_next = cnt_reg + 1'b1;
      idx_next = idx_reg;
      if (tick) begin
         cnt_next = '0;
         idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end
   end

   // Counter state; reset restarts the scan at slot 0, cycle 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
         idx_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
         idx_reg <= idx_next;
      end
   end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed scan driver for a multi-digit seven-segment display.
// New digit data is staged in a pending register and only moved to the
// displayed register at the frame wrap, so a frame is never torn.
module seven_seg_scan_driver
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
   parameter int CLK_DIV      = DEF_CLK_DIV,
   parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          load,
   input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
   input  logic                          blank_lz,
   output logic [DIGIT_W-1:0]            digit_bcd,
   output logic [NUM_DIGITS-1:0]         digit_sel,
   output logic                          digit_blank,
   output logic                          frame_done
);

   localparam int CNT_W  = $clog2(CLK_DIV);
   localparam int IDX_W  = $clog2(NUM_DIGITS);
   localparam int DATA_W = DIGIT_W * NUM_DIGITS;

   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic             tick_unused;  // only the frame boundary moves data here
   logic             frame_wrap;

   scan_tick_gen #(
      .NUM_DIGITS (NUM_DIGITS),
      .CLK_DIV    (CLK_DIV),
      .CNT_W      (CNT_W),
      .IDX_W      (IDX_W)
   ) u_tick (
      .clk        (clk),
      .rst_n      (rst_n),
      .cnt        (cnt),
      .idx        (idx),
      .tick       (tick_unused),
      .frame_wrap (frame_wrap)
   );

   logic [DATA_W-1:0] pending_reg, pending_next;
   logic              pending_valid_reg, pending_valid_next;
   logic [DATA_W-1:0] display_reg, display_next;

   // Staging: loads go to pending; the frame wrap publishes the newest value,
   // letting a load on the wrap cycle itself bypass pending.
   always_comb begin
      pending_next       = pending_reg;
      pending_valid_next = pending_valid_reg;
      display_next       = display_reg;
      if (frame_wrap) begin
         if (load)
            display_next = digits_in;
         else if (pending_valid_reg)
            display_next = pending_reg;
         pending_valid_next = 1'b0;
      end else if (load) begin
         pending_next       = digits_in;
         pending_valid_next = 1'b1;
      end
   end

   // Data registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_reg       <= '0;
         pending_valid_reg <= 1'b0;
         display_reg       <= '0;
      end else begin
         pending_reg       <= pending_next;
         pending_valid_reg <= pending_valid_next;
         display_reg       <= display_next;
      end
   end

   // Per-digit views of the displayed value and the leading-zero map.
   // upper_zero[k] is set when nibbles k..NUM_DIGITS-1 are all zero.
   logic [DIGIT_W-1:0]    nibble [NUM_DIGITS];
   logic [NUM_DIGITS:1]   upper_zero;
   logic [NUM_DIGITS-1:0] lz_blank;
   logic [NUM_DIGITS-1:0] sel_onehot;

   assign upper_zero[NUM_DIGITS] = 1'b1;
   assign lz_blank[0]            = 1'b0;  // the units digit is always shown

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign nibble[gi]     = display_reg[gi*DIGIT_W +: DIGIT_W];
         assign sel_onehot[gi] = (idx == IDX_W'(gi));
      end
      for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
         assign upper_zero[gi] = (nibble[gi] == '0) && upper_zero[gi+1];
         assign lz_blank[gi]   = blank_lz && upper_zero[gi];
      end
   endgenerate

   logic in_guard;
   generate
      if (GUARD_CYCLES == 0) begin : g_no_guard
         assign in_guard = 1'b0;
      end else begin : g_guard
         assign in_guard = (cnt < CNT_W'(GUARD_CYCLES));
      end
   endgenerate

   slot_phase_e phase;

   // Classify the current cycle of the slot.
   always_comb begin
      phase = PH_DRIVE;
      if (in_guard)
         phase = PH_GUARD;
      else if (lz_blank[idx])
         phase = PH_BLANK;
   end

   // Output decode; the enables are also held dark directly by rst_n so the
   // display goes off the instant reset asserts, even with no guard interval.
   always_comb begin
      digit_sel   = '0;
      digit_blank = 1'b1;
      if (rst_n && (phase == PH_DRIVE)) begin
         digit_sel   = sel_onehot;
         digit_blank = 1'b0;
      end
   end

   assign digit_bcd  = nibble[idx];
   assign frame_done = frame_wrap;

endmodule
